// File: rtl/rv32_scoreboard.sv
// Decode-stage register scoreboard: per-register result countdowns, RAW and multiply-unit stall generation.
// Define RV32_SCOREBOARD_PERF_EN to build the stall-cycle performance counter; otherwise it reads constant 0.
module rv32_scoreboard #(
  parameter int MAX_LAT = 4,
  parameter int MUL_II  = 3,
  parameter int LAT_W   = $clog2(MAX_LAT+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             advance,
  input  logic             issue_valid,
  input  logic             issue_wb,
  input  logic [4:0]       issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             issue_mul,
  input  logic [2:0][4:0]  rs_addr,
  input  logic [2:0]       use_rs,
  input  logic             flush,
  output logic             stall,
  output logic             stall_raw,
  output logic             stall_mul,
  output logic             issue_fire,
  output logic [31:0]      perf_stall_cycles
);
  localparam int               MB_W    = (MUL_II > 1) ? $clog2(MUL_II) : 1;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
  localparam logic [MB_W-1:0]  MB_INIT = MB_W'(MUL_II - 1);

  logic [LAT_W-1:0] w_cnt [32];
  logic [LAT_W-1:0] w_lat;
  logic             w_wr;
  logic             w_raw;
  logic [MB_W-1:0]  r_mul_busy;

  assign w_lat      = (issue_lat > LAT_MAX) ? LAT_MAX : issue_lat;
  assign w_wr       = issue_fire && issue_wb && (issue_rd != 5'd0);
  assign stall_raw  = w_raw;
  assign stall_mul  = issue_mul && (r_mul_busy != '0);
  assign stall      = issue_valid && (stall_raw || stall_mul);
  assign issue_fire = issue_valid && advance && !stall && !flush;

  // x0 never has a pending write
  assign w_cnt[0] = '0;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_dec;
    logic [LAT_W-1:0] w_nxt;

    always_comb begin
      w_dec = (r_cnt != '0) ? r_cnt - LAT_W'(1) : '0;
      w_nxt = w_dec;
      // a new write never shortens an older write's remaining wait
      if (w_wr && (issue_rd == 5'(r)) && (w_lat > w_dec)) w_nxt = w_lat;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      r_cnt <= '0;
      else if (advance) r_cnt <= w_nxt;
    end

    assign w_cnt[r] = r_cnt;
  end

  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < 3; i++)
      if (use_rs[i] && (rs_addr[i] != 5'd0) && (w_cnt[rs_addr[i]] != '0)) w_raw = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_mul_busy <= '0;
    else if (advance) begin
      if (issue_fire && issue_mul) r_mul_busy <= MB_INIT;
      else if (r_mul_busy != '0)   r_mul_busy <= r_mul_busy - MB_W'(1);
    end
  end

`ifdef RV32_SCOREBOARD_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               r_perf <= '0;
    else if (stall && advance) r_perf <= r_perf + 32'd1;
  end
  assign perf_stall_cycles = r_perf;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_rv32_scoreboard.sv
// Scoreboard bench for rv32_scoreboard: per-cycle expected {stall,stall_raw,stall_mul,issue_fire} queued and compared.
module tb_rv32_scoreboard;
  localparam int LAT_W = 3;
`ifdef RV32_SCOREBOARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             advance, issue_valid, issue_wb, issue_mul, flush;
  logic [4:0]       issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic [2:0][4:0]  rs_addr;
  logic [2:0]       use_rs;
  logic             stall, stall_raw, stall_mul, issue_fire;
  logic [31:0]      perf_stall_cycles;

  int vecs = 0;
  int errs = 0;
  int exp_perf = 0;
  logic [3:0] q [$];

  typedef struct packed {
    logic v, wb; logic [4:0] rd; logic [2:0] lat; logic mul;
    logic [4:0] rs1; logic fl, adv; logic [3:0] e;
  } vec_t;

  rv32_scoreboard dut (
    .clk(clk), .resetn(resetn), .advance(advance), .issue_valid(issue_valid),
    .issue_wb(issue_wb), .issue_rd(issue_rd), .issue_lat(issue_lat), .issue_mul(issue_mul),
    .rs_addr(rs_addr), .use_rs(use_rs), .flush(flush), .stall(stall), .stall_raw(stall_raw),
    .stall_mul(stall_mul), .issue_fire(issue_fire), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic wb, input logic [4:0] rd,
                              input logic [2:0] lat, input logic mul, input logic [4:0] rs1,
                              input logic fl, input logic adv, input logic [3:0] e);
    vec_t s;
    s.v = v; s.wb = wb; s.rd = rd; s.lat = lat; s.mul = mul;
    s.rs1 = rs1; s.fl = fl; s.adv = adv; s.e = e;
    return s;
  endfunction

  // rs2 is always x1 (never written); rs3 carries rd but is not used
  task automatic drv(input vec_t s);
    issue_valid = s.v; issue_wb = s.wb; issue_rd = s.rd; issue_lat = s.lat;
    issue_mul = s.mul; flush = s.fl; advance = s.adv;
    rs_addr[0] = s.rs1; rs_addr[1] = 5'd1; rs_addr[2] = s.rd; use_rs = 3'b011;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    resetn = 1'b0;
    drv(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b0001));
    for (int c = 0; c < 2; c++) begin
      q.push_back(4'b0001);
      #1; e = q.pop_front(); vecs++;
      if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
        errs++; $display("FAIL reset c=%0d got %b exp %b", c, {stall, stall_raw, stall_mul, issue_fire}, e);
      end
      @(negedge clk);
    end
    vecs++;
    if (perf_stall_cycles !== 32'd0) begin
      errs++; $display("FAIL reset_perf got %0d exp 0", perf_stall_cycles);
    end
    resetn = 1'b1;
    drv(mk(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000));
    @(negedge clk);
  endtask

  task automatic test_raw_load();
    vec_t t [$];
    logic [3:0] e;
    t.push_back(mk(1, 1, 5, 2, 0, 2, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b1100));
    t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b1100));
    t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b0001));
    foreach (t[c]) begin
      drv(t[c]); q.push_back(t[c].e);
      #1; e = q.pop_front(); vecs++;
      if (PERF && e[3] && advance) exp_perf++;
      if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
        errs++; $display("FAIL raw_load c=%0d got %b exp %b", c, {stall, stall_raw, stall_mul, issue_fire}, e);
      end
      @(negedge clk);
    end
    vecs++;
    if (perf_stall_cycles !== exp_perf) begin
      errs++; $display("FAIL raw_load_perf got %0d exp %0d", perf_stall_cycles, exp_perf);
    end
  endtask

  task automatic test_alu_bypass();
    vec_t t [$];
    logic [3:0] e;
    t.push_back(mk(1, 1, 7, 0, 0, 2, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 3, 0, 0, 7, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 0, 4, 0, 2, 0, 1, 4'b0001));
    t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 4'b0001));
    // latency above MAX_LAT saturates to 4
    t.push_back(mk(1, 1, 8, 7, 0, 2, 0, 1, 4'b0001));
    for (int k = 0; k < 4; k++) t.push_back(mk(1, 0, 0, 0, 0, 8, 0, 1, 4'b1100));
    t.push_back(mk(1, 0, 0, 0, 0, 8, 0, 1, 4'b0001));
    foreach (t[c]) begin
      drv(t[c]); q.push_back(t[c].e);
      #1; e = q.pop_front(); vecs++;
      if (PERF && e[3] && advance) exp_perf++;
      if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
        errs++; $display("FAIL alu_bypass c=%0d got %b exp %b", c, {stall, stall_raw, stall_mul, issue_fire}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    vec_t t [$];
    logic [3:0] e;
    int p0;
    p0 = exp_perf;
    t.push_back(mk(1, 1, 10, 0, 1, 2, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 11, 0, 1, 2, 0, 1, 4'b1010));
    t.push_back(mk(1, 1, 11, 0, 1, 2, 0, 1, 4'b1010));
    t.push_back(mk(1, 1, 11, 0, 1, 2, 0, 1, 4'b0001));
    // stall_mul is visible without issue_valid; stall is not
    t.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 4'b0010));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000));
    foreach (t[c]) begin
      drv(t[c]); q.push_back(t[c].e);
      #1; e = q.pop_front(); vecs++;
      if (PERF && e[3] && advance) exp_perf++;
      if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
        errs++; $display("FAIL mul c=%0d got %b exp %b", c, {stall, stall_raw, stall_mul, issue_fire}, e);
      end
      @(negedge clk);
    end
    vecs++;
    if (perf_stall_cycles !== exp_perf || (PERF && exp_perf - p0 != 2)) begin
      errs++; $display("FAIL mul_perf got %0d exp %0d", perf_stall_cycles, exp_perf);
    end
  endtask

  task automatic test_advance_hold();
    vec_t t [$];
    logic [3:0] e;
    t.push_back(mk(1, 1, 5, 3, 0, 2, 0, 1, 4'b0001));
    for (int k = 0; k < 4; k++) t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 0, 4'b1100));
    for (int k = 0; k < 3; k++) t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b1100));
    t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b0001));
    foreach (t[c]) begin
      drv(t[c]); q.push_back(t[c].e);
      #1; e = q.pop_front(); vecs++;
      if (PERF && e[3] && advance) exp_perf++;
      if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
        errs++; $display("FAIL advance_hold c=%0d got %b exp %b", c, {stall, stall_raw, stall_mul, issue_fire}, e);
      end
      @(negedge clk);
    end
    vecs++;
    if (perf_stall_cycles !== exp_perf) begin
      errs++; $display("FAIL advance_hold_perf got %0d exp %0d", perf_stall_cycles, exp_perf);
    end
  endtask

  task automatic test_waw();
    vec_t t [$];
    logic [3:0] e;
    t.push_back(mk(1, 1, 5, 3, 0, 2, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 5, 1, 0, 2, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b1100));
    t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b1100));
    t.push_back(mk(1, 1, 6, 0, 0, 5, 0, 1, 4'b0001));
    // add x13,x13,x1: reads old x13 state, no self-stall
    t.push_back(mk(1, 1, 13, 2, 0, 13, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 6, 0, 0, 13, 0, 1, 4'b1100));
    t.push_back(mk(1, 1, 6, 0, 0, 13, 0, 1, 4'b1100));
    t.push_back(mk(1, 1, 6, 0, 0, 13, 0, 1, 4'b0001));
    foreach (t[c]) begin
      drv(t[c]); q.push_back(t[c].e);
      #1; e = q.pop_front(); vecs++;
      if (PERF && e[3] && advance) exp_perf++;
      if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
        errs++; $display("FAIL waw c=%0d got %b exp %b", c, {stall, stall_raw, stall_mul, issue_fire}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_reset();
    vec_t t [$];
    logic [3:0] e;
    t.push_back(mk(1, 1, 9, 3, 0, 2, 1, 1, 4'b0000));
    t.push_back(mk(1, 1, 6, 0, 0, 9, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 9, 3, 0, 2, 0, 1, 4'b0001));
    t.push_back(mk(1, 1, 6, 0, 0, 9, 1, 1, 4'b1100));
    foreach (t[c]) begin
      drv(t[c]); q.push_back(t[c].e);
      #1; e = q.pop_front(); vecs++;
      if (PERF && e[3] && advance) exp_perf++;
      if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
        errs++; $display("FAIL flush c=%0d got %b exp %b", c, {stall, stall_raw, stall_mul, issue_fire}, e);
      end
      @(negedge clk);
    end
    // x9 now pending with cnt=2; reset mid-cycle must drop the stall at once
    drv(mk(1, 1, 6, 0, 0, 9, 0, 1, 4'b1100));
    q.push_back(4'b1100); q.push_back(4'b0001); q.push_back(4'b0001);
    #1; e = q.pop_front(); vecs++;
    if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
      errs++; $display("FAIL pre_reset got %b exp %b", {stall, stall_raw, stall_mul, issue_fire}, e);
    end
    resetn = 1'b0; exp_perf = 0;
    #1; e = q.pop_front(); vecs++;
    if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
      errs++; $display("FAIL mid_reset got %b exp %b", {stall, stall_raw, stall_mul, issue_fire}, e);
    end
    vecs++;
    if (perf_stall_cycles !== exp_perf) begin
      errs++; $display("FAIL mid_reset_perf got %0d exp %0d", perf_stall_cycles, exp_perf);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1; e = q.pop_front(); vecs++;
    if ({stall, stall_raw, stall_mul, issue_fire} !== e) begin
      errs++; $display("FAIL post_reset got %b exp %b", {stall, stall_raw, stall_mul, issue_fire}, e);
    end
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    drv(mk(0, 0, 0, 0, 0, 0, 0, 1, 4'b0000));
    @(negedge clk);
    test_reset();
    test_raw_load();
    test_alu_bypass();
    test_mul();
    test_advance_hold();
    test_waw();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rv32_scoreboard.md
# rv32_scoreboard

Register scoreboard and issue controller for the decode stage. Tracks every in-flight register write with a per-register countdown of cycles until its result is forwardable. Stalls issue on read-after-write hazards against the decoder's `use_rs` sources, and on structural hazards against the non-pipelined multiply unit. Sits between the instruction decoder and the execute stage and drives the decode-stage stall.

## Interface
Parameters:
- `MAX_LAT`, default 4: largest result latency any unit reports, in cycles.
- `MUL_II`, default 3: initiation interval of the multiply unit, in cycles (at least 1).
- `LAT_W`, default `$clog2(MAX_LAT+1)`: width of the latency fields.

Ports (clock and reset first):
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `advance` in 1: pipeline moves this cycle; 0 freezes all countdowns.
- `issue_valid` in 1: decode presents an instruction.
- `issue_wb` in 1: instruction writes `issue_rd` (decoder `register_wb`).
- `issue_rd` in 5: destination register.
- `issue_lat` in `LAT_W`: cycles a consumer must wait after the producer issues (0 = ALU bypass).
- `issue_mul` in 1: instruction uses the multiply unit.
- `rs_addr[3]` in 5 each: rs1, rs2, rs3 (rs3 = rd).
- `use_rs[3]` in 1 each: decoder source-use flags.
- `flush` in 1: cancels the instruction presented this cycle.
- `stall` out 1: combinational; decode must hold its instruction.
- `stall_raw` out 1: stall caused by a data hazard.
- `stall_mul` out 1: stall caused by the multiply unit being busy.
- `issue_fire` out 1: the instruction is accepted this cycle.
- `perf_stall_cycles` out 32: count of stall cycles (see Configuration).

## Operation
- State:
  - `cnt[1..31]`, each `LAT_W` bits. `x0` has no entry and is never pending.
  - `mul_busy`, a `$clog2(MUL_II)`-bit countdown.
- Hazard detection:
  - `stall_raw` = OR over i of (`use_rs[i]` & `rs_addr[i]`≠0 & `cnt[rs_addr[i]]`≠0).
  - `stall_mul` = `issue_mul` & `mul_busy`≠0.
  - `stall` = `issue_valid` & (`stall_raw` | `stall_mul`).
  - `stall_raw` and `stall_mul` are not qualified by `issue_valid`. `stall` is.
- Issue: `issue_fire` = `issue_valid` & `advance` & ~`stall` & ~`flush`.
- Per-register update at the clock edge, only when `advance`=1; registers hold otherwise:
  - If `issue_fire` & `issue_wb` & `issue_rd`≠0 and r = `issue_rd`: `cnt[r]` ← max(`cnt[r]`−1 saturating at 0, `issue_lat`). This is a WAW-safe merge.
  - Otherwise: `cnt[r]` ← `cnt[r]`−1 if nonzero.
- Multiply unit update, only when `advance`=1:
  - If `issue_fire` & `issue_mul`: `mul_busy` ← `MUL_II`−1.
  - Otherwise: `mul_busy` decrements if nonzero.
- A consumer of a producer that issued in cycle t with latency L can issue no earlier than cycle t+1+L, counting only `advance` cycles.
- `issue_lat` > `MAX_LAT` saturates to `MAX_LAT`.

## Timing
- Reset: all `cnt` = 0, `mul_busy` = 0, `perf_stall_cycles` = 0.
  - Outputs during and after reset: `stall`=0, `stall_raw`=0, `stall_mul`=0, `issue_fire`=`issue_valid`&`advance`&~`flush`.
- Reset asserted mid-operation clears all pending state immediately. No pending write survives reset.
- `stall` has zero latency: combinational from `rs_addr`, `use_rs`, `issue_*` and the registered state.
- Source equals destination in the same instruction (e.g. `add x5,x5,x1`): `stall` is evaluated against the old `cnt` only. The instruction does not stall on itself.
- `flush` together with a hazard: `stall` still reflects the hazard, but no state changes.
- `advance`=0 while `cnt` is nonzero: the countdown holds and stalls persist.
- L=0 producer: no stall for a back-to-back consumer.

## Configuration
- `RV32_SCOREBOARD_PERF_EN` defined:
  - `perf_stall_cycles` increments (wrapping at 2^32) every cycle with `stall`=1 & `advance`=1.
  - It is cleared only by reset.
- Not defined:
  - `perf_stall_cycles` is constant 0.
  - No counter flops are synthesized.

## Test plan
- Load x5 with `issue_lat`=2, then `add x6,x5,x1` presented every cycle → `stall_raw`=1 for 2 cycles, `issue_fire`=1 on the 3rd cycle.
- ALU write x7 with lat 0, then a consumer of x7 the next cycle → no stall. Writes to x0 with lat 4 → never stall.
- Two back-to-back `issue_mul`, `MUL_II`=3 → second instruction has `stall_mul`=1 for 2 cycles, then fires. With `PERF_EN`, `perf_stall_cycles`=2.
- x5 pending with `cnt`=3, `advance`=0 for 4 cycles → `cnt` stays 3 and stall persists. After `advance` returns, the consumer fires after 3 more cycles.
- WAW: x5 issued with lat 3, then x5 issued with lat 1 → `cnt[x5]`=2, and the consumer waits 2 cycles.
- `flush`=1 on a lat 3 write to x9 → no pending x9. Reset asserted with x9 pending at `cnt`=2 → stall drops to 0 immediately.
